// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the IF/MEM single-port RAM arbiter.
// Read-return owner encodings, default starvation limit, common data words,
// and the lane-containment helper used by the optional misalignment check
// (MEM_ARB_MISALIGN_CHK_EN).
package mem_arbiter_pkg;

   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_IF   = 2'd1;
   localparam logic [1:0] OWNER_LS   = 2'd2;

   localparam int unsigned STARVE_MAX_DEF = 4;

   localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
   localparam logic [3:0]  READ_ENABLE = 4'b0000;

   // Misaligned when a requested lane sits below the address byte offset.
   function automatic logic misaligned(input logic [1:0] off, input logic [3:0] be);
      logic [3:0] lanes_ok;
      lanes_ok = 4'b1111 << off;
      return (off != 2'b00) && ((be & ~lanes_ok) != 4'b0000);
   endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts consecutive cycles in which a pending fetch loses
// the RAM to load/store, saturating at STARVE_MAX; force_if requests that the
// next contested cycle go to the fetch port.
module mem_arb_starve_ctr
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic arst_n,
   input  logic if_req,
   input  logic ls_req,
   input  logic if_gnt,
   input  logic ls_gnt,
   output logic force_if
);

   localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

   logic [3:0] cnt_q, cnt_d;

   // Next count: clear on fetch progress or no fetch pending, bump on a lost contest.
   always_comb begin
      cnt_d = cnt_q;
      if (if_gnt || !if_req) begin
         cnt_d = '0;
      end else if (ls_req && ls_gnt && (cnt_q != MAX_CNT)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!arst_n) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign force_if = (cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between IF fetch and MEM load/store.
// MEM has fixed priority; a starvation counter forces an IF grant after
// STARVE_MAX lost contests. Reads return exactly one cycle after the grant.
// Optional: define MEM_ARB_MISALIGN_CHK_EN to add ls_misalign_o and retire
// misaligned load/store requests without touching the RAM.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [3:0]        ls_be,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              stall_if_o,
   output logic              stall_mem_o
`ifdef MEM_ARB_MISALIGN_CHK_EN
   ,
   output logic              ls_misalign_o
`endif
);

   logic [1:0] rd_owner_q, rd_owner_d;
   logic       force_if;
   logic       ls_bad;
   logic       ls_go;

`ifdef MEM_ARB_MISALIGN_CHK_EN
   assign ls_bad        = misaligned(ls_addr[1:0], ls_we ? ls_be : 4'b1111);
   assign ls_misalign_o = ls_gnt & ls_bad;
`else
   assign ls_bad = 1'b0;
`endif

   // LS grant that actually reaches the RAM (misaligned requests are retired only).
   assign ls_go = ls_gnt & ~ls_bad;

   mem_arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .arst_n  (arst_n),
      .if_req  (if_req),
      .ls_req  (ls_req),
      .if_gnt  (if_gnt),
      .ls_gnt  (ls_gnt),
      .force_if(force_if)
   );

   // Grant selection: MEM wins unless the fetch has been starved; all grants held low in reset.
   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (arst_n) begin
         if (if_req && (!ls_req || force_if)) if_gnt = 1'b1;
         else if (ls_req)                     ls_gnt = 1'b1;
      end
   end

   assign stall_if_o  = arst_n & if_req & ~if_gnt;
   assign stall_mem_o = arst_n & ls_req & ~ls_gnt;

   // RAM port drive from the winning requester; idle drives all zero.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = READ_ENABLE;
      ram_addr  = '0;
      ram_wdata = '0;
      if (if_gnt) begin
         ram_en   = 1'b1;
         ram_addr = if_addr;
      end else if (ls_go) begin
         ram_en    = 1'b1;
         ram_addr  = ls_addr;
         ram_wdata = ls_wdata;
         ram_we    = ls_we ? ls_be : READ_ENABLE;
      end
   end

   // Owner of the read data returning next cycle; stores and idle cycles own nothing.
   always_comb begin
      rd_owner_d = OWNER_NONE;
      if (if_gnt)                rd_owner_d = OWNER_IF;
      else if (ls_go && !ls_we)  rd_owner_d = OWNER_LS;
   end

   // Read-owner register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!arst_n) rd_owner_q <= OWNER_NONE;
      else         rd_owner_q <= rd_owner_d;
   end

   assign if_rvalid = arst_n & (rd_owner_q == OWNER_IF);
   assign ls_rvalid = arst_n & (rd_owner_q == OWNER_LS);
   assign if_rdata  = if_rvalid ? ram_rdata : ZERO_WORD;
   assign ls_rdata  = ls_rvalid ? ram_rdata : ZERO_WORD;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// cycle-level reference model (lost-contest streak, pending read return,
// reference memory image).
module tb_mem_arbiter;

   localparam int unsigned STARVE = 4;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic [3:0]  ls_be;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_en;
   logic [31:0] if_rdata, ls_rdata, ram_addr, ram_wdata;
   logic [3:0]  ram_we;
   logic [31:0] ram_rdata = 32'h0;
   logic        stall_if_o, stall_mem_o;
`ifdef MEM_ARB_MISALIGN_CHK_EN
   logic        ls_misalign_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .STARVE_MAX(STARVE)
   ) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .ls_req     (ls_req),
      .ls_we      (ls_we),
      .ls_be      (ls_be),
      .ls_addr    (ls_addr),
      .ls_wdata   (ls_wdata),
      .ls_gnt     (ls_gnt),
      .ls_rvalid  (ls_rvalid),
      .ls_rdata   (ls_rdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .stall_if_o (stall_if_o),
      .stall_mem_o(stall_mem_o)
`ifdef MEM_ARB_MISALIGN_CHK_EN
      ,
      .ls_misalign_o(ls_misalign_o)
`endif
   );

   function automatic logic [31:0] init_word(input logic [7:0] i);
      case (i)
         8'd64:   return 32'h0050_0093;   // byte address 0x100
         8'd128:  return 32'h1122_3344;   // byte address 0x200
         default: return {i, ~i, i ^ 8'h5A, 8'hC3};
      endcase
   endfunction

   // RAM behavioural model: 256 words, one-cycle read latency, byte-lane writes.
   logic [31:0] mem [256];
   logic        ram_init = 1'b0;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
      end else if (ram_en) begin
         if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr[9:2]];
         else
            for (int b = 0; b < 4; b++)
               if (ram_we[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [256];
   int unsigned m_lost;          // consecutive cycles IF wanted the RAM and LS got it
   int unsigned m_pend;          // 0 none, 1 fetch return, 2 load return
   logic [31:0] m_pend_data;
   logic        last_if_gnt, last_ls_gnt;

   // Snapshots of the last sampled cycle for directed checks
   logic        obs_if_gnt, obs_stall_if, obs_ram_en, obs_misalign;
   logic [3:0]  obs_ram_we;
   logic [31:0] obs_if_rdata, obs_ls_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample 1ns after inputs settle, compare, advance model, step clock.
   task automatic tick();
      logic        e_if, e_ls, e_bad, e_en, e_ifv, e_lsv, e_mis;
      logic [3:0]  e_we, need;
      logic [31:0] e_addr, e_wd, e_ifd, e_lsd;
      #1;
      e_if = 0; e_ls = 0; e_bad = 0; e_ifv = 0; e_lsv = 0;
      e_ifd = 32'h0; e_lsd = 32'h0;
      if (arst_n) begin
         e_ifv = (m_pend == 1);
         e_lsv = (m_pend == 2);
         if (e_ifv) e_ifd = m_pend_data;
         if (e_lsv) e_lsd = m_pend_data;
         e_if = if_req && (!ls_req || m_lost == STARVE);
         e_ls = ls_req && !e_if;
`ifdef MEM_ARB_MISALIGN_CHK_EN
         need = ls_we ? ls_be : 4'hF;
         for (int b = 0; b < 4; b++)
            if (need[b] && b < int'(ls_addr[1:0])) e_bad = 1'b1;
`else
         need = 4'h0;
`endif
      end else begin
         need = 4'h0;
      end
      e_mis  = e_ls && e_bad;
      e_en   = e_if || (e_ls && !e_bad);
      e_we   = (e_ls && !e_bad && ls_we) ? ls_be : 4'b0000;
      e_addr = e_if ? if_addr : ((e_ls && !e_bad) ? ls_addr : 32'h0);
      e_wd   = (e_ls && !e_bad) ? ls_wdata : 32'h0;

      chk("if_gnt", 32'(if_gnt), 32'(e_if));
      chk("ls_gnt", 32'(ls_gnt), 32'(e_ls));
      chk("stall_if", 32'(stall_if_o), 32'(arst_n && if_req && !e_if));
      chk("stall_mem", 32'(stall_mem_o), 32'(arst_n && ls_req && !e_ls));
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", ram_addr, e_addr);
      if (!e_if) chk("ram_wdata", ram_wdata, e_wd);
      chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
      chk("if_rdata", if_rdata, e_ifd);
      chk("ls_rvalid", 32'(ls_rvalid), 32'(e_lsv));
      chk("ls_rdata", ls_rdata, e_lsd);
`ifdef MEM_ARB_MISALIGN_CHK_EN
      chk("ls_misalign", 32'(ls_misalign_o), 32'(e_mis));
      obs_misalign = ls_misalign_o;
`else
      obs_misalign = e_mis;
`endif
      obs_if_gnt   = if_gnt;
      obs_stall_if = stall_if_o;
      obs_ram_en   = ram_en;
      obs_ram_we   = ram_we;
      obs_if_rdata = if_rdata;
      obs_ls_rdata = ls_rdata;

      if (!arst_n) begin
         m_lost = 0;
         m_pend = 0;
      end else begin
         if (e_if) begin
            m_pend = 1; m_pend_data = ref_mem[if_addr[9:2]];
         end else if (e_ls && !ls_we && !e_bad) begin
            m_pend = 2; m_pend_data = ref_mem[ls_addr[9:2]];
         end else begin
            m_pend = 0;
         end
         if (e_ls && ls_we && !e_bad)
            for (int b = 0; b < 4; b++)
               if (ls_be[b]) ref_mem[ls_addr[9:2]][8*b +: 8] = ls_wdata[8*b +: 8];
         m_lost = (if_req && e_ls) ? m_lost + 1 : 0;
      end
      last_if_gnt = e_if;
      last_ls_gnt = e_ls;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Retire requests that were granted in the last cycle.
   task automatic settle();
      if (last_if_gnt) if_req = 1'b0;
      if (last_ls_gnt) ls_req = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
   endfunction

   logic [7:0] gnt_vec, stall_vec;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
      m_lost = 0; m_pend = 0; m_pend_data = 32'h0;
      last_if_gnt = 0; last_ls_gnt = 0;
      arst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF;
      if_addr = 32'h104; ls_addr = 32'h208; ls_wdata = 32'h0;

      // Reset held two cycles with both requests pending
      ram_init = 1'b1;
      tick();
      ram_init = 1'b0;
      tick();
      chk("reset_ram_en", 32'(obs_ram_en), 32'h0);

      // Release: LS wins the first cycle
      arst_n = 1'b1;
      tick();
      chk("post_reset_ls_first", 32'(obs_if_gnt), 32'h0);
      settle();
      tick(); settle();
      tick(); settle();

      // Fetch only from 0x100
      if_req = 1'b1; if_addr = 32'h100;
      tick(); settle();
      tick();
      chk("fetch_word", obs_if_rdata, 32'h0050_0093);
      chk("fetch_no_stall", 32'(obs_stall_if), 32'h0);

      // Partial store then load of 0x200
      ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h200; ls_wdata = 32'hAABB_CCDD;
      tick(); settle();
      chk("store_ram_we", 32'(obs_ram_we), 32'h3);
      ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF;
      tick(); settle();
      tick();
      chk("load_merged", obs_ls_rdata, 32'h1122_CCDD);

      // Store with no byte enables
      ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0000; ls_addr = 32'h200; ls_wdata = 32'hFFFF_FFFF;
      tick(); settle();
      ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF;
      tick(); settle();
      tick();
      chk("be0_store_no_change", obs_ls_rdata, 32'h1122_CCDD);

      // Contention: both held 8 cycles, IF forced through on cycle STARVE
      if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; if_addr = rnd_addr(); ls_addr = rnd_addr();
      for (int c = 0; c < 8; c++) begin
         tick();
         gnt_vec[c]   = obs_if_gnt;
         stall_vec[c] = obs_stall_if;
         if (last_if_gnt) if_addr = rnd_addr();
         if (last_ls_gnt) ls_addr = rnd_addr();
      end
      chk("contention_if_gnt", 32'(gnt_vec), 32'h10);
      chk("contention_stall_if", 32'(stall_vec), 32'hEF);
      if_req = 1'b0; ls_req = 1'b0;
      tick();

      // Back-to-back loads alternating with fetches
      for (int c = 0; c < 8; c++) begin
         if (c % 2 == 0) begin
            ls_req = 1'b1; ls_we = 1'b0; ls_addr = rnd_addr();
         end else begin
            if_req = 1'b1; if_addr = rnd_addr();
         end
         tick(); settle();
         chk("b2b_ram_en", 32'(obs_ram_en), 32'h1);
      end
      tick();

      // Reset arriving the cycle after a load grant discards the return
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h040;
      tick(); settle();
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
      tick();

`ifdef MEM_ARB_MISALIGN_CHK_EN
      // Misaligned load is retired without a RAM access
      ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h202;
      tick(); settle();
      chk("misalign_pulse", 32'(obs_misalign), 32'h1);
      chk("misalign_no_ram", 32'(obs_ram_en), 32'h0);
      tick();
`endif

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         if (!if_req && $urandom_range(0, 99) < 60) begin
            if_req = 1'b1; if_addr = rnd_addr();
         end
         if (!ls_req && $urandom_range(0, 99) < 60) begin
            ls_req   = 1'b1;
            ls_we    = 1'($urandom_range(0, 1));
            ls_be    = 4'($urandom_range(0, 15));
            ls_addr  = rnd_addr();
            ls_wdata = $urandom;
         end
         if ($urandom_range(0, 199) == 0) arst_n = 1'b0;
         else arst_n = 1'b1;
         tick();
         if (arst_n) settle();
      end
      arst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
